// File: rtl/playlist_sequencer.sv
// playlist_sequencer: play/pause/next/prev/repeat-mode controller that drives the
// song reader and note player (play, reset_play, song).
// Optional feature: define PLAYLIST_SHUFFLE_EN to add the SHUFFLE mode (mode 3)
// and the 8-bit LFSR that picks shuffled songs.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_RST   | one-cycle restart pulse to reader/player; song already stable
// ST_PAUSE | playback halted, note position held
// ST_PLAY  | playback running, song_done sampled here only
module playlist_sequencer #(
    parameter int SONG_BITS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 play_pause,
    input  logic                 next,
    input  logic                 prev,
    input  logic                 mode_btn,
    input  logic                 song_done,
    output logic                 play,
    output logic                 reset_play,
    output logic [SONG_BITS-1:0] song,
    output logic [1:0]           mode
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_PAUSE = 2'd1,
        ST_PLAY  = 2'd2
    } state_t;

    localparam logic [SONG_BITS-1:0] SONG_LAST = '1;
    localparam logic [SONG_BITS-1:0] SONG_ONE  = SONG_BITS'(1);

    localparam logic [1:0] MODE_NORMAL     = 2'd0;
    localparam logic [1:0] MODE_REPEAT_ALL = 2'd1;
    localparam logic [1:0] MODE_REPEAT_ONE = 2'd2;
`ifdef PLAYLIST_SHUFFLE_EN
    localparam logic [1:0] MODE_SHUFFLE    = 2'd3;
    localparam logic [1:0] MODE_LAST       = 2'd3;
`else
    localparam logic [1:0] MODE_LAST       = 2'd2;
`endif

    state_t               state, state_next;
    logic                 resume, resume_next;
    logic [SONG_BITS-1:0] song_next;
    logic [1:0]           mode_next;
    logic                 play_next, reset_play_next;

    logic [SONG_BITS-1:0] song_inc, song_dec;
    // song chosen by a forward skip (next, or song_done in the skipping modes)
    logic [SONG_BITS-1:0] skip_pick;

    assign song_inc = song + SONG_ONE;
    assign song_dec = song - SONG_ONE;

`ifdef PLAYLIST_SHUFFLE_EN
    logic [7:0]           lfsr;
    logic                 lfsr_fb;
    logic [SONG_BITS-1:0] shuffle_cand;
    logic [SONG_BITS-1:0] shuffle_pick;

    // taps for x^8 + x^6 + x^5 + x^4 + 1
    assign lfsr_fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign shuffle_cand = lfsr[SONG_BITS-1:0];
    // bump a candidate that matches the current song so a shuffle always moves
    assign shuffle_pick = (shuffle_cand == song) ? shuffle_cand + SONG_ONE : shuffle_cand;
    assign skip_pick    = (mode == MODE_SHUFFLE) ? shuffle_pick : song_inc;

    // free-running shuffle source, restarted from a fixed seed on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr <= 8'hA5;
        end else begin
            lfsr <= {lfsr[6:0], lfsr_fb};
        end
    end
`else
    assign skip_pick = song_inc;
`endif

    // repeat-mode button runs independently of the playback FSM
    always_comb begin
        mode_next = mode;
        if (mode_btn) begin
            mode_next = (mode == MODE_LAST) ? 2'd0 : mode + 2'd1;
        end
    end

    // next-state, next-song and resume decision; song_done > next > prev > play_pause
    always_comb begin
        state_next  = state;
        resume_next = resume;
        song_next   = song;
        case (state)
            ST_RST: begin
                state_next = resume ? ST_PLAY : ST_PAUSE;
            end
            ST_PAUSE: begin
                if (next) begin
                    song_next   = skip_pick;
                    resume_next = 1'b0;
                    state_next  = ST_RST;
                end else if (prev) begin
                    song_next   = song_dec;
                    resume_next = 1'b0;
                    state_next  = ST_RST;
                end else if (play_pause) begin
                    state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (song_done) begin
                    state_next  = ST_RST;
                    resume_next = 1'b1;
                    case (mode)
                        MODE_NORMAL: begin
                            if (song == SONG_LAST) begin
                                song_next   = '0;
                                resume_next = 1'b0;
                            end else begin
                                song_next = song_inc;
                            end
                        end
                        MODE_REPEAT_ALL: song_next = song_inc;
                        MODE_REPEAT_ONE: song_next = song;
                        default:         song_next = skip_pick;
                    endcase
                end else if (next) begin
                    song_next   = skip_pick;
                    resume_next = 1'b1;
                    state_next  = ST_RST;
                end else if (prev) begin
                    song_next   = song_dec;
                    resume_next = 1'b1;
                    state_next  = ST_RST;
                end else if (play_pause) begin
                    state_next = ST_PAUSE;
                end
            end
            default: begin
                state_next  = ST_RST;
                resume_next = 1'b0;
            end
        endcase
    end

    // outputs are registered, so decode them from the state being entered
    always_comb begin
        play_next       = (state_next == ST_PLAY);
        reset_play_next = (state_next == ST_RST);
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_RST;
            resume     <= 1'b0;
            song       <= '0;
            mode       <= MODE_NORMAL;
            play       <= 1'b0;
            reset_play <= 1'b1;
        end else begin
            state      <= state_next;
            resume     <= resume_next;
            song       <= song_next;
            mode       <= mode_next;
            play       <= play_next;
            reset_play <= reset_play_next;
        end
    end

endmodule
